// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with mid-bit sampling, done tick and framing-error pulse
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [15:0]          baud_div,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 rx_done_tick_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [15:0]            cnt_q, cnt_d, div_q, div_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d, dout_q, dout_d;
    logic                   done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic                   rx_s;
    assign rx_s           = sync_q[SYNC_STAGES-1];
    assign sync_d         = {sync_q[SYNC_STAGES-2:0], rx_i};
    assign dout_o         = dout_q;
    assign rx_done_tick_o = done_q;
    assign frame_err_o    = err_q;
    assign busy_o         = busy_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = '0;
                div_d   = baud_div;
            end
            START: if (cnt_q == (div_q >> 1) - 16'd1) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            DATA: if (cnt_q == div_q - 16'd1) begin
                cnt_d   = '0;
                sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 4'd1;
                state_d = (bit_q == LAST_BIT) ? STOP : DATA;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            STOP: if (cnt_q == div_q - 16'd1) begin
                cnt_d   = '0;
                dout_d  = rx_s ? sh_q : dout_q;
                done_d  = rx_s;
                err_d   = !rx_s;
                state_d = rx_s ? IDLE : BREAK;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx driving serial frames directly on rx_i
module tb_uart_rx;
    typedef struct packed {logic e; logic [7:0] d;} exp_t;
    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [15:0] bd = 16'd868;
    logic [7:0]  dout;
    logic        done, err, busy;
    int          total = 0, bad = 0, cyc = 0, fall_cyc = 0, done_cyc = 0;
    logic [7:0]  last_dout = 8'h00;
    exp_t        q[$];

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .baud_div(bd),
        .dout_o(dout), .rx_done_tick_o(done), .frame_err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input int div);
        drive(1'b0, div);
        for (int i = 0; i < 8; i++) drive(d[i], div);
        drive(1'b1, div);
    endtask

    task automatic expect_ok(input logic [7:0] d);
        q.push_back('{e: 1'b0, d: d});
        last_dout = d;
    endtask

    always @(negedge clk) begin
        if (done && err) chk("done_and_err", 1, 0);
        if (done || err) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", {30'd0, err, done}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_kind_err", int'(err), int'(e.e));
                chk("tick_dout", int'(dout), int'(e.d));
            end
            if (done) done_cyc = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        drive(1'b1, 5);

        expect_ok(8'hA5);
        fall_cyc = cyc;
        frame(8'hA5, 868);
        drive(1'b1, 4);
        chk("a5_latency", done_cyc - fall_cyc, 434 + 9 * 868 + 2 + 1);
        chk("a5_busy_after", int'(busy), 0);

        drive(1'b0, 50);
        chk("glitch_busy_mid", int'(busy), 1);
        drive(1'b0, 50);
        drive(1'b1, 600);
        chk("glitch_busy_after", int'(busy), 0);

        bd = 16'd16;
        q.push_back('{e: 1'b1, d: last_dout});
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(8'h3C >> i & 8'h01, 16);
        drive(1'b0, 32);
        chk("break_busy", int'(busy), 1);
        drive(1'b1, 48);
        chk("err_dout_kept", int'(dout), 8'hA5);
        expect_ok(8'h81);
        frame(8'h81, 16);
        drive(1'b1, 16);

        expect_ok(8'h00);
        expect_ok(8'hFF);
        frame(8'h00, 16);
        frame(8'hFF, 16);
        drive(1'b1, 32);

        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(8'h77 >> i & 8'h01, 16);
        drive(1'b1, 8);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        last_dout = 8'h00;
        drive(1'b1, 64);
        expect_ok(8'h5A);
        frame(8'h5A, 16);
        drive(1'b1, 32);

        bd = 16'd24;
        for (int k = 0; k < 20; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            expect_ok(b);
            frame(b, 24);
        end
        drive(1'b1, 48);

        for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("final_dout", int'(dout), int'(last_dout));
        chk("final_busy", int'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
